rr_mux_n: RTL and testbench
===========================

# rr_mux_n

Parametrised N-channel, W-bit multiplexer with valid/ready handshakes and one registered output stage. It selects among CHANNELS input streams either round-robin or by an explicit select, and holds the winner in an output register until the consumer takes it. It sits between multiple datapath producers (register-file read ports, forwarding sources, memory return paths) and a single consumer stage. It generalises the 1-bit 4:1 combinational mux to arbitrary width and channel count, adding flow control.

## Interface
- WIDTH, 64, data width per channel in bits (≥1)
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, $clog2(CHANNELS), derived; do not override
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- mode  input  1  0 = round-robin arbitration, 1 = fixed select via sel
- sel  input  SEL_W  channel index used when mode=1; values ≥CHANNELS select nothing
- in_data  input  CHANNELS*WIDTH  packed input words; channel k at [k*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready, at most one bit high (one-hot or zero)
- out_data  output  WIDTH  registered selected word
- out_chan  output  SEL_W  registered index of the channel that supplied out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Reset values: out_valid=0, out_data=0, out_chan=0, round-robin pointer last=CHANNELS-1 (first search starts at channel 0).
- load_en = !out_valid || out_ready: the output register is empty or drains this cycle.
- Grant, combinational:
  - mode=0: first k with in_valid[k]=1, searching last+1, last+2, … mod CHANNELS (wrap-around).
  - mode=1: k=sel if sel<CHANNELS and in_valid[sel]=1; otherwise no grant.
- in_ready[k] = load_en && grant==k. All zero when there is no grant or load_en=0.
- Input transfer on channel k = in_valid[k] && in_ready[k]. On a transfer: out_data←in_data[k], out_chan←k, out_valid←1.
- Output transfer = out_valid && out_ready. Output transfer without an input transfer: out_valid←0. out_data and out_chan hold their last values.
- Simultaneous output and input transfer in one cycle: the register is reloaded and out_valid stays 1. There is no bubble.
- Pointer update: last←k only on an input transfer, in either mode. It holds otherwise, including on mode switches.
- Producers must keep in_data and in_valid stable while valid and not granted. The block never drops or duplicates an accepted word.
- mode and sel may change on any cycle. They take effect combinationally on that cycle's grant.

## Timing
- Latency: 1 cycle. A word accepted at edge t appears on out_data with out_valid=1 after edge t.
- Throughput: 1 word per cycle while out_ready=1 and any eligible channel is valid.
- in_ready depends combinationally on out_ready, in_valid, mode, sel and the pointer. There is no combinational path from in_data to any output.
- Back-pressure: with out_ready=0 and out_valid=1, all in_ready=0 and out_data and out_chan are frozen.
- Reset asserted mid-operation: on the next edge, all state takes its reset values regardless of handshakes in flight. The word in the output register is discarded. in_ready is forced to 0 while reset=1.
- Fairness in mode=0: with all channels continuously valid and out_ready=1, the grants cycle 0,1,…,CHANNELS-1,0,… in order. Each channel waits at most CHANNELS-1 transfers.

## Test plan
- Reset, then mode=0, all in_valid=1, channel k data = 0x100+k, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 and out_data 0x100..0x103 repeated. out_valid=1 from the 2nd cycle onward.
- mode=0, in_valid=4'b1010, out_ready=1 -> grants alternate 1,3,1,3. in_ready[0] and in_ready[2] are never asserted.
- mode=1, sel=2, in_valid=4'b1111 for 4 cycles, then in_valid[2]=0 -> out_chan=2 every cycle, then no grant and out_valid falls after the last word drains.
- Back-pressure: one word loaded, out_ready=0 for 3 cycles with all in_valid=1 -> in_ready=0, and out_data and out_chan stay stable. With out_ready=1, the next word loads in the same cycle (no bubble).
- WIDTH=1, CHANNELS=4, mode=1, sweep in_data 0..15 × sel 0..3 -> out_data = in_data[sel] one cycle later, for all 64 cases.
- Assert reset while out_valid=1 and a transfer is pending -> next cycle out_valid=0, out_data=0, out_chan=0. The first grant after release is channel 0.

Source files
------------

// File: rtl/rr_mux_n.sv
// ---------------------------------------------------------------------------
// rr_mux_n
//
// Parametrised N-channel, W-bit multiplexer with valid/ready flow control and
// a single registered output stage. Channels are chosen either round-robin
// (mode=0) or by an explicit channel index (mode=1). The chosen word is held
// in the output register until the consumer takes it.
//
// Parameters
//   WIDTH     data width per channel in bits (>= 1)
//   CHANNELS  number of input channels (>= 2)
//   SEL_W     derived index width, $clog2(CHANNELS); do not override
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   mode       0 = round-robin arbitration, 1 = fixed select via sel
//   sel        channel index used when mode=1; out-of-range selects nothing
//   in_data    packed input words, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered selected word
//   out_chan   registered index of the channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts out_data this cycle
// ---------------------------------------------------------------------------
module rr_mux_n #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Index of the most recently granted channel; the round-robin search
    // begins one past it.
    logic [SEL_W-1:0] last;

    logic             rr_found;
    logic [SEL_W-1:0] rr_idx;
    int               rr_pos;

    logic             fix_found;
    logic [SEL_W-1:0] fix_idx;

    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             load_en;
    logic             take;
    logic [WIDTH-1:0] grant_data;

    // Round-robin search: scan last+1, last+2, ... with wrap-around and stop
    // at the first valid channel. The scan covers all CHANNELS positions, so
    // the previously granted channel is considered last.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_pos   = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            rr_pos = int'(last) + i;
            if (rr_pos >= CHANNELS) begin
                rr_pos = rr_pos - CHANNELS;
            end
            if (!rr_found && in_valid[rr_pos]) begin
                rr_found = 1'b1;
                rr_idx   = SEL_W'(rr_pos);
            end
        end
    end

    // Fixed select: compare sel against every legal index rather than using
    // sel as an array index, so an out-of-range sel simply matches nothing.
    always_comb begin
        fix_found = 1'b0;
        fix_idx   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k) && in_valid[k]) begin
                fix_found = 1'b1;
                fix_idx   = SEL_W'(k);
            end
        end
    end

    // The register may load when empty or when it drains this same cycle,
    // which is what gives back-to-back transfers with no bubble. Reset blocks
    // any transfer so no producer believes a word was accepted.
    always_comb begin
        grant_valid = mode ? fix_found : rr_found;
        grant_idx   = mode ? fix_idx   : rr_idx;
        load_en     = !out_valid || out_ready;
        take        = grant_valid && load_en && !reset;
    end

    // One-hot ready towards the producers and the matching data word.
    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                in_ready[k] = take;
                grant_data  = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer. A load has priority over a
    // drain so that a simultaneous in/out transfer keeps out_valid high.
    // On a plain drain only out_valid falls; data and channel hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            last      <= SEL_W'(CHANNELS - 1);
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_chan  <= grant_idx;
            last      <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_n.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_n
//
// Self-checking bench for rr_mux_n. A 16-bit, 4-channel instance exercises
// round-robin order, sparse valids, fixed select, back-pressure, mode
// switching and reset during a pending transfer. A 1-bit, 4-channel instance
// is swept over every data pattern and select value.
// ---------------------------------------------------------------------------
module tb_rr_mux_n;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int SW = 2;

    logic            clk;
    logic            reset;

    logic            mode;
    logic [SW-1:0]   sel;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_chan;
    logic            out_valid;
    logic            out_ready;

    logic            w1_mode;
    logic [SW-1:0]   w1_sel;
    logic [CH-1:0]   w1_in_data;
    logic [CH-1:0]   w1_in_valid;
    logic [CH-1:0]   w1_in_ready;
    logic [0:0]      w1_out_data;
    logic [SW-1:0]   w1_out_chan;
    logic            w1_out_valid;
    logic            w1_out_ready;

    int assert_count;
    int fail_count;

    typedef struct {
        logic          mode;
        logic [SW-1:0] sel;
        logic [CH-1:0] valid;
        logic          ordy;
        logic [CH-1:0] exp_ready;
        logic          exp_ov;
        logic [SW-1:0] exp_chan;
        logic [W-1:0]  exp_data;
    } vec_t;

    vec_t vecs[$];

    rr_mux_n #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    rr_mux_n #(.WIDTH(1), .CHANNELS(CH)) dut_w1 (
        .clk       (clk),
        .reset     (reset),
        .mode      (w1_mode),
        .sel       (w1_sel),
        .in_data   (w1_in_data),
        .in_valid  (w1_in_valid),
        .in_ready  (w1_in_ready),
        .out_data  (w1_out_data),
        .out_chan  (w1_out_chan),
        .out_valid (w1_out_valid),
        .out_ready (w1_out_ready)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Append one cycle to the vector table.
    task automatic addVec(input logic m, input logic [SW-1:0] s,
                          input logic [CH-1:0] v, input logic r,
                          input logic [CH-1:0] er, input logic eov,
                          input logic [SW-1:0] ec, input logic [W-1:0] ed);
        vec_t t;
        t.mode = m; t.sel = s; t.valid = v; t.ordy = r;
        t.exp_ready = er; t.exp_ov = eov; t.exp_chan = ec; t.exp_data = ed;
        vecs.push_back(t);
    endtask

    // Drive one cycle on the wide instance: inputs at the falling edge,
    // in_ready checked before the rising edge, registers checked after it.
    task automatic applyStimulus(input string tag, input logic r, input logic m,
                                 input logic [SW-1:0] s, input logic [CH-1:0] v,
                                 input logic ordy, input logic [CH-1:0] er,
                                 input logic eov, input logic [SW-1:0] ec,
                                 input logic [W-1:0] ed);
        @(negedge clk);
        reset     = r;
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = ordy;
        #1;
        checkOutput({tag, " in_ready"}, 32'(in_ready), 32'(er));
        @(posedge clk);
        #1;
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(eov));
        checkOutput({tag, " out_chan"}, 32'(out_chan), 32'(ec));
        checkOutput({tag, " out_data"}, 32'(out_data), 32'(ed));
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;

        for (int k = 0; k < CH; k++) begin
            in_data[k*W +: W] = W'(16'h100 + k);
        end
        reset        = 1'b1;
        mode         = 1'b0;
        sel          = '0;
        in_valid     = '0;
        out_ready    = 1'b0;
        w1_mode      = 1'b1;
        w1_sel       = '0;
        w1_in_data   = '0;
        w1_in_valid  = '0;
        w1_out_ready = 1'b1;

        // Round-robin with every channel valid: 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 8; i++) begin
            addVec(1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001 << (i % 4), 1'b1,
                   SW'(i % 4), W'(16'h100 + (i % 4)));
        end
        // Sparse valids 1010: grants alternate 1,3.
        for (int i = 0; i < 4; i++) begin
            addVec(1'b0, 2'd0, 4'b1010, 1'b1,
                   (i % 2 == 0) ? 4'b0010 : 4'b1000, 1'b1,
                   (i % 2 == 0) ? 2'd1 : 2'd3,
                   (i % 2 == 0) ? 16'h101 : 16'h103);
        end
        // Fixed select on channel 2, then channel 2 drops out.
        for (int i = 0; i < 4; i++) begin
            addVec(1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h102);
        end
        addVec(1'b1, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd2, 16'h102);
        addVec(1'b1, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd2, 16'h102);
        // Back-pressure: load channel 3, stall 3 cycles, then reload channel 0
        // on the draining cycle, then drain to empty.
        addVec(1'b0, 2'd0, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 16'h103);
        for (int i = 0; i < 3; i++) begin
            addVec(1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 16'h103);
        end
        addVec(1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h100);
        addVec(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h100);
        // Mode switch: fixed select on an idle channel grants nothing, then
        // round-robin wraps past the pointer back to channel 0.
        addVec(1'b1, 2'd1, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h100);
        addVec(1'b0, 2'd1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h100);

        // Reset state, with in_ready held low while reset is asserted.
        in_valid = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", 32'(in_ready), 32'h0);
        checkOutput("reset out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset out_chan", 32'(out_chan), 32'h0);
        checkOutput("reset out_data", 32'(out_data), 32'h0);

        foreach (vecs[i]) begin
            applyStimulus($sformatf("vec%0d", i), 1'b0, vecs[i].mode,
                          vecs[i].sel, vecs[i].valid, vecs[i].ordy,
                          vecs[i].exp_ready, vecs[i].exp_ov,
                          vecs[i].exp_chan, vecs[i].exp_data);
        end

        // Reset while a word is held and another transfer would happen: the
        // word is discarded and round-robin restarts from channel 0.
        applyStimulus("rst_load", 1'b0, 1'b0, 2'd0, 4'b1111, 1'b1,
                      4'b0010, 1'b1, 2'd1, 16'h101);
        applyStimulus("rst_mid", 1'b1, 1'b0, 2'd0, 4'b1111, 1'b1,
                      4'b0000, 1'b0, 2'd0, 16'h000);
        applyStimulus("rst_after", 1'b0, 1'b0, 2'd0, 4'b1111, 1'b1,
                      4'b0001, 1'b1, 2'd0, 16'h100);

        // One-bit instance: every data pattern against every select.
        w1_in_valid = 4'b1111;
        for (int d = 0; d < 16; d++) begin
            for (int s = 0; s < 4; s++) begin
                logic [3:0] dv;
                dv = 4'(d);
                @(negedge clk);
                w1_in_data = dv;
                w1_sel     = SW'(s);
                @(posedge clk);
                #1;
                checkOutput($sformatf("w1 d%0d s%0d data", d, s),
                            32'(w1_out_data), 32'(dv[s]));
                checkOutput($sformatf("w1 d%0d s%0d chan", d, s),
                            32'(w1_out_chan), 32'(s));
            end
        end
        checkOutput("w1 out_valid", 32'(w1_out_valid), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
